// File: rtl/sraml_sram_responder.sv
// sraml_sram_responder
//   Slave end of the sram-like bus. Requests are accepted whenever fewer than
//   DEPTH are outstanding. Each accepted request is forwarded to a synchronous
//   single-port SRAM in the same cycle. It is answered with a one-cycle data_ok
//   pulse exactly LATENCY cycles later, and answers come back in acceptance order.
//
// Parameters
//   AW       bus address width; the RAM word index is addr_i[RAW+1:2]
//   RAW      RAM word-address width
//   DEPTH    maximum outstanding requests (>=1)
//   LATENCY  cycles from accept to data_ok (>=1)
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   req_i        request valid
//   wr_i         1 = write, 0 = read
//   size_i       0 byte, 1 half, 2/3 word
//   addr_i       byte address
//   wdata_i      lane-aligned write data
//   addr_ok_o    request accepted this cycle when req_i & addr_ok_o
//   data_ok_o    one pulse per accepted request, in order
//   rdata_o      RAM word for reads while data_ok_o, otherwise 0
//   ram_en_o     SRAM access strobe
//   ram_wen_o    SRAM byte write enables
//   ram_addr_o   SRAM word address
//   ram_wdata_o  SRAM write data
//   ram_rdata_i  SRAM read data, valid the cycle after ram_en_o
module sraml_sram_responder #(
  parameter int AW      = 32,
  parameter int RAW     = 16,
  parameter int DEPTH   = 2,
  parameter int LATENCY = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_i,
  input  logic            wr_i,
  input  logic [1:0]      size_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [31:0]     wdata_i,
  output logic            addr_ok_o,
  output logic            data_ok_o,
  output logic [31:0]     rdata_o,
  output logic            ram_en_o,
  output logic [3:0]      ram_wen_o,
  output logic [RAW-1:0]  ram_addr_o,
  output logic [31:0]     ram_wdata_o,
  input  logic [31:0]     ram_rdata_i
);

  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNW = $clog2(DEPTH + 1);
  localparam int LW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNW-1:0] DEPTH_C  = CNW'(DEPTH);
  localparam logic [LW-1:0]  CD_INIT  = LW'(LATENCY - 1);
  localparam logic [IW-1:0]  LAST_IDX = IW'(DEPTH - 1);

  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    byte_mask = 4'b0001 << off;
      2'd1:    byte_mask = off[1] ? 4'b1100 : 4'b0011;
      default: byte_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    next_idx = (idx == LAST_IDX) ? '0 : idx + IW'(1);
  endfunction

  logic [CNW-1:0]  count_q, count_d;
  logic [IW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0] vld_q, wr_q;
  logic [LW-1:0]   cd_q [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic            cap_vld_q;
  logic [IW-1:0]   cap_idx_q;
  logic            accept;
  logic            bypass;
  logic            unused_addr;

  // Only the word-index bits and the byte offset of the address are meaningful.
  assign unused_addr = ^(addr_i >> (RAW + 2));

  // addr_ok_o depends only on state, never on req_i. A slot freed by this
  // cycle's data_ok_o is not reused until the next cycle.
  assign addr_ok_o   = rst_ni & (count_q < DEPTH_C);
  assign accept      = req_i & addr_ok_o;

  assign ram_en_o    = accept;
  assign ram_wen_o   = (accept & wr_i) ? byte_mask(size_i, addr_i[1:0]) : 4'b0000;
  assign ram_addr_o  = addr_i[RAW+1:2];
  assign ram_wdata_o = wdata_i;

  assign data_ok_o   = vld_q[head_q] & (cd_q[head_q] == '0);

  // When the head entry was accepted last cycle (always true for LATENCY=1),
  // its word is still on ram_rdata_i and has not been captured yet.
  assign bypass      = cap_vld_q & (cap_idx_q == head_q);
  assign rdata_o     = (data_ok_o & ~wr_q[head_q]) ?
                       (bypass ? ram_rdata_i : data_q[head_q]) : 32'h0;

  always_comb begin
    count_d = count_q;
    case ({accept, data_ok_o})
      2'b10:   count_d = count_q + CNW'(1);
      2'b01:   count_d = count_q - CNW'(1);
      default: count_d = count_q;
    endcase
    head_d = data_ok_o ? next_idx(head_q) : head_q;
    tail_d = accept    ? next_idx(tail_q) : tail_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      vld_q     <= '0;
      wr_q      <= '0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      for (int i = 0; i < DEPTH; i++) cd_q[i] <= '0;
    end else begin
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      cap_vld_q <= accept & ~wr_i;
      cap_idx_q <= tail_q;
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && cd_q[i] != '0) cd_q[i] <= cd_q[i] - LW'(1);
      end
      if (data_ok_o) vld_q[head_q] <= 1'b0;
      if (accept) begin
        vld_q[tail_q] <= 1'b1;
        wr_q[tail_q]  <= wr_i;
        cd_q[tail_q]  <= CD_INIT;
      end
    end
  end

  // Read data storage: the SRAM word arrives the cycle after the accept.
  always_ff @(posedge clk_i) begin
    if (cap_vld_q) data_q[cap_idx_q] <= ram_rdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && data_ok_o) assert (count_q != '0);
    if (rst_ni) assert (count_q <= DEPTH_C);
  end

endmodule
